alu_op_sequencer: RTL and testbench

- Hardwired control sequencer for the bus datapath. Replaces hand-driven T0..T5 control with a state machine.
- Fetches one instruction (PC to MAR, PC+1, memory read into MDR, MDR to IR) and executes a register-register ALU operation.
- Generates one-hot register select, ALU opcode and all bus/latch strobes. Adds a memory-ready handshake with timeout, illegal-instruction trap, a two-cycle HI/LO writeback for mul/div, and back-to-back issue.

---
 rtl/alu_op_sequencer_if.sv | 30 +++
 rtl/alu_op_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bus/strobe bundle between the control sequencer and the datapath.
interface alu_op_sequencer_if #(
  parameter int unsigned REG_COUNT = 16
);
  logic                 Start;
  logic                 Mem_ready;
  logic [31:0]          IR;
  logic                 PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, PCin;
  logic                 ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin;
  logic [REG_COUNT-1:0] Rout;
  logic [REG_COUNT-1:0] Rin;
  logic [4:0]           ALU_op;
  logic                 Busy, Done, Illegal, Fault;

  // Sequencer side
  modport master (
    input  Start, Mem_ready, IR,
    output PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, PCin,
    output ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin,
    output Rout, Rin, ALU_op, Busy, Done, Illegal, Fault
  );

  // Datapath / requester side
  modport slave (
    output Start, Mem_ready, IR,
    input  PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, PCin,
    input  ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin,
    input  Rout, Rin, ALU_op, Busy, Done, Illegal, Fault
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Hardwired fetch/execute control sequencer for the bus datapath: fetches one
// instruction, then runs a register-register ALU op with optional HI/LO writeback.
module alu_op_sequencer #(
  parameter int unsigned REG_COUNT   = 16,
  parameter int unsigned WAIT_MAX    = 15,
  parameter logic [31:0] ALU_MASK    = 32'h0001_FFF8,
  parameter logic [31:0] MULDIV_MASK = 32'h0000_C000
) (
  input  logic               Clock,
  input  logic               Clear,
  alu_op_sequencer_if.master bus
);

  localparam int unsigned CW     = $clog2(WAIT_MAX + 2);
  localparam logic [15:0] REG_OK = (REG_COUNT >= 16) ? 16'hFFFF
                                 : 16'((32'd1 << REG_COUNT) - 32'd1);

  typedef enum logic [3:0] {IDLE, T0, T1, TW, T2, T3, T4, T5, T6} state_t;

  typedef struct packed {
    logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, PCin;
    logic ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin;
    logic [REG_COUNT-1:0] Rout;
    logic [REG_COUNT-1:0] Rin;
    logic [4:0] ALU_op;
    logic Busy, Done, Illegal;
  } outs_t;

  state_t        state, nstate;
  logic [CW-1:0] wait_cnt, nwait_cnt;
  logic [4:0]    op_q, op_n;
  logic [3:0]    ra_q, rb_q, rc_q, ra_n, rb_n, rc_n;
  outs_t         out_q, out_n;
  logic          fault_n;

  function automatic logic [REG_COUNT-1:0] onehot(input logic [3:0] idx);
    logic [REG_COUNT-1:0] v;
    for (int unsigned i = 0; i < REG_COUNT; i++) v[i] = (32'(idx) == i);
    return v;
  endfunction

  function automatic logic is_illegal(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc);
    return !ALU_MASK[op] || !REG_OK[rb] || !REG_OK[rc] ||
           (!MULDIV_MASK[op] && !REG_OK[ra]);
  endfunction

  // Next state, wait counter, field latching and the timeout fault.
  always_comb begin
    nstate    = state;
    nwait_cnt = wait_cnt;
    op_n      = op_q;
    ra_n      = ra_q;
    rb_n      = rb_q;
    rc_n      = rc_q;
    fault_n   = 1'b0;
    case (state)
      IDLE: if (bus.Start) nstate = T0;
      T0:   nstate = T1;
      T1: begin
        nstate    = TW;
        nwait_cnt = '0;
      end
      TW: begin
        if (bus.Mem_ready) begin
          nstate    = T2;
          nwait_cnt = '0;
        end else if (wait_cnt == CW'(WAIT_MAX)) begin
          fault_n   = 1'b1;
          nstate    = IDLE;
          nwait_cnt = '0;
        end else begin
          nwait_cnt = wait_cnt + CW'(1);
        end
      end
      T2: begin
        nstate = T3;
        op_n   = bus.IR[31:27];
        ra_n   = bus.IR[26:23];
        rb_n   = bus.IR[22:19];
        rc_n   = bus.IR[18:15];
      end
      T3:      nstate = is_illegal(op_q, ra_q, rb_q, rc_q) ? IDLE : T4;
      T4:      nstate = T5;
      T5:      nstate = MULDIV_MASK[op_q] ? T6 : (bus.Start ? T0 : IDLE);
      T6:      nstate = bus.Start ? T0 : IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs are decoded for the state being entered so they register with it.
  always_comb begin
    out_n      = '0;
    out_n.Busy = (nstate != IDLE);
    case (nstate)
      T0: begin
        out_n.PCout  = 1'b1;
        out_n.MARin  = 1'b1;
        out_n.IncPC  = 1'b1;
        out_n.ZLowIn = 1'b1;
      end
      T1: begin
        out_n.Zlowout = 1'b1;
        out_n.PCin    = 1'b1;
      end
      TW: begin
        out_n.Read  = 1'b1;
        out_n.MDRin = 1'b1;
      end
      T2: begin
        out_n.MDRout = 1'b1;
        out_n.IRin   = 1'b1;
      end
      T3: begin
        if (is_illegal(op_n, ra_n, rb_n, rc_n)) begin
          out_n.Illegal = 1'b1;
        end else begin
          out_n.Rout = onehot(rb_n);
          out_n.Yin  = 1'b1;
        end
      end
      T4: begin
        out_n.Rout    = onehot(rc_n);
        out_n.ALU_op  = op_n;
        out_n.ZLowIn  = 1'b1;
        out_n.ZHighIn = MULDIV_MASK[op_n];
      end
      T5: begin
        out_n.Zlowout = 1'b1;
        if (MULDIV_MASK[op_n]) begin
          out_n.LOin = 1'b1;
        end else begin
          out_n.Rin  = onehot(ra_n);
          out_n.Done = 1'b1;
        end
      end
      T6: begin
        out_n.ZHighout = 1'b1;
        out_n.HIin     = 1'b1;
        out_n.Done     = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter, latched fields and registered outputs; Clear dominates.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state    <= IDLE;
      wait_cnt <= '0;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      out_q    <= '0;
    end else begin
      state    <= nstate;
      wait_cnt <= nwait_cnt;
      op_q     <= op_n;
      ra_q     <= ra_n;
      rb_q     <= rb_n;
      rc_q     <= rc_n;
      out_q    <= out_n;
    end
  end

  assign bus.PCout    = out_q.PCout;
  assign bus.MARin    = out_q.MARin;
  assign bus.IncPC    = out_q.IncPC;
  assign bus.Read     = out_q.Read;
  assign bus.MDRin    = out_q.MDRin;
  assign bus.MDRout   = out_q.MDRout;
  assign bus.IRin     = out_q.IRin;
  assign bus.Yin      = out_q.Yin;
  assign bus.PCin     = out_q.PCin;
  assign bus.ZLowIn   = out_q.ZLowIn;
  assign bus.ZHighIn  = out_q.ZHighIn;
  assign bus.Zlowout  = out_q.Zlowout;
  assign bus.ZHighout = out_q.ZHighout;
  assign bus.HIin     = out_q.HIin;
  assign bus.LOin     = out_q.LOin;
  assign bus.Rout     = out_q.Rout;
  assign bus.Rin      = out_q.Rin;
  assign bus.ALU_op   = out_q.ALU_op;
  assign bus.Busy     = out_q.Busy;
  assign bus.Done     = out_q.Done;
  assign bus.Illegal  = out_q.Illegal;
  // Timeout is flagged in the very wait cycle that exhausts the budget.
  assign bus.Fault    = fault_n;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed and random instructions checked cycle by
// cycle against an expected-trace model, plus a reduced register-count instance.
module tb_alu_op_sequencer;

  localparam int WAIT_MAX = 15;
  localparam logic [31:0] ALU_MASK    = 32'h0001_FFF8;
  localparam logic [31:0] MULDIV_MASK = 32'h0000_C000;

  typedef struct packed {
    logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, PCin;
    logic ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic [4:0] ALU_op;
    logic Busy, Done, Illegal, Fault;
  } vec_t;

  typedef struct {
    vec_t  v;
    bit    tw;
    bit    rdy;
    bit    fin;
    bit    keep;
    string tag;
  } cyc_t;

  logic Clock, Clear;
  int   n_cmp = 0;
  int   n_err = 0;
  cyc_t exp_q[$];

  alu_op_sequencer_if #(.REG_COUNT(16)) b ();
  alu_op_sequencer_if #(.REG_COUNT(8))  b8 ();

  alu_op_sequencer #(.REG_COUNT(16), .WAIT_MAX(15), .ALU_MASK(ALU_MASK),
                     .MULDIV_MASK(MULDIV_MASK))
    dut (.Clock(Clock), .Clear(Clear), .bus(b));

  alu_op_sequencer #(.REG_COUNT(8), .WAIT_MAX(15), .ALU_MASK(ALU_MASK),
                     .MULDIV_MASK(MULDIV_MASK))
    dut8 (.Clock(Clock), .Clear(Clear), .bus(b8));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t obs();
    vec_t v;
    v.PCout = b.PCout;   v.MARin = b.MARin;     v.IncPC = b.IncPC;
    v.Read = b.Read;     v.MDRin = b.MDRin;     v.MDRout = b.MDRout;
    v.IRin = b.IRin;     v.Yin = b.Yin;         v.PCin = b.PCin;
    v.ZLowIn = b.ZLowIn; v.ZHighIn = b.ZHighIn; v.Zlowout = b.Zlowout;
    v.ZHighout = b.ZHighout; v.HIin = b.HIin;   v.LOin = b.LOin;
    v.Rout = b.Rout;     v.Rin = b.Rin;         v.ALU_op = b.ALU_op;
    v.Busy = b.Busy;     v.Done = b.Done;       v.Illegal = b.Illegal;
    v.Fault = b.Fault;
    return v;
  endfunction

  task automatic push(input vec_t v, input bit tw, input bit rdy, input bit fin,
                      input bit keep, input string tag);
    cyc_t c;
    c.v = v; c.tw = tw; c.rdy = rdy; c.fin = fin; c.keep = keep; c.tag = tag;
    exp_q.push_back(c);
  endtask

  // Expected per-cycle trace of one instruction, derived from the state rules.
  task automatic build(input logic [31:0] ir, input int nwait);
    vec_t v;
    int op, ra, rb, rc, ntw;
    bit md, ill;
    op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    md = MULDIV_MASK[op];
    exp_q.delete();
    v = '0; v.Busy = 1; v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.ZLowIn = 1;
    push(v, 0, 0, 0, 1, "T0");
    v = '0; v.Busy = 1; v.Zlowout = 1; v.PCin = 1;
    push(v, 0, 0, 0, 1, "T1");
    ntw = (nwait > WAIT_MAX) ? WAIT_MAX + 1 : nwait + 1;
    for (int i = 0; i < ntw; i++) begin
      v = '0; v.Busy = 1; v.Read = 1; v.MDRin = 1;
      if (nwait > WAIT_MAX && i == ntw - 1) v.Fault = 1;
      push(v, 1, (nwait <= WAIT_MAX && i == nwait), 0, 1, "TW");
    end
    if (nwait > WAIT_MAX) return;
    v = '0; v.Busy = 1; v.MDRout = 1; v.IRin = 1;
    push(v, 0, 0, 0, 1, "T2");
    ill = !ALU_MASK[op] || rb >= 16 || rc >= 16 || (!md && ra >= 16);
    v = '0; v.Busy = 1;
    if (ill) begin
      v.Illegal = 1;
      push(v, 0, 0, 0, 0, "T3_illegal");
      return;
    end
    v.Rout = 16'(1 << rb); v.Yin = 1;
    push(v, 0, 0, 0, 0, "T3");
    v = '0; v.Busy = 1; v.Rout = 16'(1 << rc); v.ALU_op = 5'(op); v.ZLowIn = 1; v.ZHighIn = md;
    push(v, 0, 0, 0, 0, "T4");
    if (md) begin
      v = '0; v.Busy = 1; v.Zlowout = 1; v.LOin = 1;
      push(v, 0, 0, 0, 0, "T5_lo");
      v = '0; v.Busy = 1; v.ZHighout = 1; v.HIin = 1; v.Done = 1;
      push(v, 0, 0, 1, 0, "T6_hi");
    end else begin
      v = '0; v.Busy = 1; v.Zlowout = 1; v.Rin = 16'(1 << ra); v.Done = 1;
      push(v, 0, 0, 1, 0, "T5");
    end
  endtask

  task automatic step(input logic st, input logic mr, input logic [31:0] ir, input logic clr);
    @(posedge Clock); #1;
    b.Start = st; b.Mem_ready = mr; b.IR = ir; Clear = clr;
    @(negedge Clock);
  endtask

  task automatic issue();
    step(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'b1);
    check("idle_issue", obs(), '0);
  endtask

  // Runs one instruction whose T0 is the next cycle; clear_at >= 0 pulls Clear
  // low during that trace cycle and checks the machine is back in IDLE after.
  task automatic run_op(input logic [31:0] ir, input int nwait, input bit chain,
                        input int clear_at, output bit chained);
    logic st, mr, clr;
    logic [31:0] irv;
    chained = 0;
    build(ir, nwait);
    for (int i = 0; i < exp_q.size(); i++) begin
      st  = 1'($urandom_range(0, 1));
      mr  = exp_q[i].tw ? exp_q[i].rdy : 1'($urandom_range(0, 1));
      irv = exp_q[i].keep ? ir : $urandom;
      if (exp_q[i].fin) st = chain;
      clr = (i == clear_at) ? 1'b0 : 1'b1;
      step(st, mr, irv, clr);
      check(exp_q[i].tag, obs(), exp_q[i].v);
      if (i == clear_at) begin
        step(1'b0, 1'b0, ir, 1'b1);
        check("clear_mid_op", obs(), '0);
        return;
      end
      if (exp_q[i].fin && chain) chained = 1;
    end
  endtask

  // Reduced-register instance: cycle numbers counted from T0 = 1.
  task automatic run8(input logic [31:0] ir, input bit exp_ill, input logic [7:0] exp_rout3,
                      input int exp_done);
    int ill_c, done_c;
    logic [7:0] r3;
    logic y3;
    ill_c = -1; done_c = -1; r3 = '0; y3 = 1'b0;
    @(posedge Clock); #1;
    b8.Start = 1'b1; b8.IR = ir; b8.Mem_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge Clock); #1;
      b8.Start = 1'b0;
      @(negedge Clock);
      if (b8.Illegal) ill_c = c;
      if (b8.Done && done_c < 0) done_c = c;
      if (c == 5) begin r3 = b8.Rout; y3 = b8.Yin; end
    end
    check("r8_illegal_cycle", 64'(ill_c), exp_ill ? 64'd5 : 64'(-1));
    check("r8_T3_Rout", 64'(r3), 64'(exp_rout3));
    check("r8_T3_Yin", 64'(y3), 64'(!exp_ill));
    check("r8_done_cycle", 64'(done_c), 64'(exp_done));
    check("r8_idle_after", 64'(b8.Busy), 64'd0);
  endtask

  initial begin
    bit ch;
    logic [31:0] ir;
    int nw, r;
    Clear = 1'b0;
    b.Start = 1'b1; b.Mem_ready = 1'b1; b.IR = '0;
    b8.Start = 1'b0; b8.Mem_ready = 1'b0; b8.IR = '0;

    // Reset held with Start high, then released idle.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 32'h4A920000, 1'b0);
      check("reset", obs(), '0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h4A920000, 1'b1);
      check("idle_after_reset", obs(), '0);
    end

    issue(); run_op(32'h4A920000, 0, 0, -1, ch);   // ADD R5 = R2 op R4
    issue(); run_op(32'h70338000, 0, 0, -1, ch);   // mul R6, R7 -> HI/LO
    issue(); run_op(32'h4A920000, 3, 0, -1, ch);   // three not-ready cycles
    issue(); run_op(32'h4A920000, 99, 0, -1, ch);  // timeout
    issue(); run_op(32'h00000000, 0, 0, -1, ch);   // illegal opcode 0
    issue(); run_op(32'h4A920000, 0, 0, 5, ch);    // Clear during T4
    issue(); run_op(32'h4A920000, 0, 1, -1, ch);   // back-to-back pair
    run_op(32'h4A920000, 0, 0, -1, ch);

    ch = 0;
    for (int n = 0; n < 60; n++) begin
      ir = $urandom;
      if ($urandom_range(0, 3) != 0) ir[31:27] = 5'($urandom_range(3, 16));
      r  = $urandom_range(0, 9);
      nw = (r == 0) ? 20 : (r <= 6) ? 0 : $urandom_range(1, 5);
      if (!ch) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b1);
          check("idle_gap", obs(), '0);
        end
        issue();
      end
      run_op(ir, nw, 1'($urandom_range(0, 1)), -1, ch);
    end
    if (ch) run_op(32'h4A920000, 0, 0, -1, ch);
    step(1'b0, 1'b0, '0, 1'b1);
    check("idle_end", obs(), '0);

    run8({5'd9, 4'd1, 4'd9, 4'd2, 15'd0}, 1'b1, 8'h00, -1);   // Rb = 9
    run8({5'd9, 4'd5, 4'd3, 4'd2, 15'd0}, 1'b0, 8'h08, 7);    // legal add
    run8({5'd14, 4'd12, 4'd1, 4'd2, 15'd0}, 1'b0, 8'h02, 8);  // mul ignores Ra
    run8({5'd9, 4'd12, 4'd1, 4'd2, 15'd0}, 1'b1, 8'h00, -1);  // Ra = 12

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
